// File: rtl/key_event_sequencer_pkg.sv
// Shared types and helpers for the whack-a-mole keypad path.
//   KEY_W            : key code width ({column[1:0], row[1:0]})
//   ROW_MAX/COL_MAX  : highest populated row/column index on the 3x3 pad
//   kes_state_e      : keypad re-arm sequencer states
//   is_legal_key()   : true for the nine populated key positions
package wam_keypad_pkg;

  localparam int unsigned KEY_W = 4;

  localparam logic [1:0] ROW_MAX = 2'd2;
  localparam logic [1:0] COL_MAX = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REARM  = 2'd1,
    SETTLE = 2'd2
  } kes_state_e;

  // Column in the upper two bits, row in the lower two.
  function automatic logic is_legal_key(input logic [KEY_W-1:0] key);
    return (key[3:2] <= COL_MAX) && (key[1:0] <= ROW_MAX);
  endfunction

endpackage

// File: rtl/key_event_sequencer_fifo.sv
// Synchronous FIFO with registered head, occupancy and flags.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write request / data (accepted if not full, or full with a pop)
//   pop        : read request (ignored when empty)
//   flush      : empties the FIFO, overrides push and pop
//   dout       : head entry (0 when empty)
//   count      : occupancy
//   full/empty : registered occupancy flags
module key_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] count_n;
  logic [WIDTH-1:0] dout_n;

  // Accepted operations, next occupancy and next head value.
  always_comb begin
    do_pop  = pop && !empty && !flush;
    do_push = push && (!full || do_pop) && !flush;

    count_n = count;
    if (flush)
      count_n = '0;
    else if (do_push && !do_pop)
      count_n = count + CNT_W'(1);
    else if (!do_push && do_pop)
      count_n = count - CNT_W'(1);

    // Head register tracks what mem[rd_ptr] will hold after this edge.
    dout_n = dout;
    if (flush)
      dout_n = '0;
    else if (do_pop) begin
      if (count > CNT_W'(1))
        dout_n = mem[rd_ptr + AW'(1)];
      else if (do_push)
        dout_n = din;
      else
        dout_n = '0;
    end else if (empty && do_push)
      dout_n = din;
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_n;
      dout  <= dout_n;
      full  <= (count_n == CNT_W'(DEPTH));
      empty <= (count_n == '0);
    end
  end

endmodule

// File: rtl/key_event_sequencer.sv
// Bridges keypad_controller to the game logic: synchronises valid/key,
// captures each press once, filters illegal codes, queues legal ones and
// re-arms the keypad by pulsing its active-low clear.
//   clk, reset          : system clock, synchronous active-high reset
//   kp_valid_key, kp_key: keypad outputs (foreign domain)
//   kp_clear_n          : keypad clear, low for REARM_CYCLES per capture
//   flush               : empties queue and clears overflow
//   ev_valid/ev_key/ev_ready : head-of-queue handshake
//   count               : queue occupancy
//   overflow            : sticky, a legal key was dropped on a full queue
//   bad_key             : one-cycle pulse for a dropped illegal code
module key_event_sequencer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned KEY_W        = 4,
  parameter int unsigned REARM_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   kp_valid_key,
  input  logic [KEY_W-1:0]       kp_key,
  output logic                   kp_clear_n,
  input  logic                   flush,
  output logic                   ev_valid,
  output logic [KEY_W-1:0]       ev_key,
  input  logic                   ev_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   bad_key
);

  import wam_keypad_pkg::*;

  localparam int unsigned RC_W = $clog2(REARM_CYCLES);

  logic             vk_s1;
  logic             vk_s;
  logic [KEY_W-1:0] key_s1;
  logic [KEY_W-1:0] key_s;

  kes_state_e       state;
  logic [RC_W-1:0]  rearm_cnt;
  logic             zero_seen;

  logic             capture;
  logic             legal;
  logic             push_req;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;

  // Two-flop synchronisers; key and valid advance together so key_s is
  // settled whenever vk_s is seen high.
  always_ff @(posedge clk) begin
    if (reset) begin
      vk_s1  <= 1'b0;
      vk_s   <= 1'b0;
      key_s1 <= '0;
      key_s  <= '0;
    end else begin
      vk_s1  <= kp_valid_key;
      vk_s   <= vk_s1;
      key_s1 <= kp_key;
      key_s  <= key_s1;
    end
  end

  // Capture decision for the current cycle.
  always_comb begin
    capture  = (state == IDLE) && vk_s;
    legal    = is_legal_key(key_s);
    push_req = capture && legal;
    drop     = push_req && fifo_full && !(ev_valid && ev_ready) && !flush;
  end

  // Re-arm sequencer: capture in IDLE, hold clear low in REARM, then wait
  // in SETTLE for two quiet cycles so stale synchroniser state is gone.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= REARM;
      rearm_cnt  <= '0;
      zero_seen  <= 1'b0;
      kp_clear_n <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (vk_s) begin
            state      <= REARM;
            rearm_cnt  <= '0;
            kp_clear_n <= 1'b0;
          end
        end
        REARM: begin
          if (rearm_cnt == RC_W'(REARM_CYCLES - 1)) begin
            state      <= SETTLE;
            zero_seen  <= 1'b0;
            kp_clear_n <= 1'b1;
          end else begin
            rearm_cnt <= rearm_cnt + RC_W'(1);
          end
        end
        SETTLE: begin
          if (!vk_s) begin
            zero_seen <= 1'b1;
            if (zero_seen) state <= IDLE;
          end else begin
            zero_seen <= 1'b0;
          end
        end
        default: begin
          state      <= REARM;
          rearm_cnt  <= '0;
          kp_clear_n <= 1'b0;
        end
      endcase
    end
  end

  // Status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      bad_key  <= 1'b0;
    end else begin
      overflow <= flush ? 1'b0 : (overflow || drop);
      bad_key  <= capture && !legal;
    end
  end

  key_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (ev_ready),
    .flush (flush),
    .din   (key_s),
    .dout  (ev_key),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_valid = !fifo_empty;

endmodule

// File: tb/tb_key_event_sequencer.sv
// Directed bench for key_event_sequencer: legality table plus hand-written
// sequences for reset, overflow, full push/pop, flush and mid-rearm reset.
module tb_key_event_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       kp_valid_key;
  logic [3:0] kp_key;
  logic       kp_clear_n;
  logic       flush;
  logic       ev_valid;
  logic [3:0] ev_key;
  logic       ev_ready;
  logic [2:0] count;
  logic       overflow;
  logic       bad_key;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       pre_clr;
    logic       clr;
    logic       bad;
    logic [2:0] cnt;
    logic       ov;
    logic       evv;
    logic [3:0] evk;
    logic       bad_after;
    int         width;
  } obs_t;

  typedef struct {
    logic [3:0] key;
    logic       exp_bad;
  } vec_t;

  key_event_sequencer #(
    .DEPTH        (4),
    .KEY_W        (4),
    .REARM_CYCLES (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .kp_valid_key (kp_valid_key),
    .kp_key       (kp_key),
    .kp_clear_n   (kp_clear_n),
    .flush        (flush),
    .ev_valid     (ev_valid),
    .ev_key       (ev_key),
    .ev_ready     (ev_ready),
    .count        (count),
    .overflow     (overflow),
    .bad_key      (bad_key)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One keypad press: valid rises, capture lands on the third edge; ready
  // and flush are asserted only for the capture cycle.
  task automatic press(input logic [3:0] k, input logic rdy, input logic fl, output obs_t o);
    kp_key       = k;
    kp_valid_key = 1'b1;
    tick();
    tick();
    o.pre_clr = kp_clear_n;
    ev_ready  = rdy;
    flush     = fl;
    tick();
    o.clr = kp_clear_n;
    o.bad = bad_key;
    o.cnt = count;
    o.ov  = overflow;
    o.evv = ev_valid;
    o.evk = ev_key;
    ev_ready     = 1'b0;
    flush        = 1'b0;
    kp_valid_key = 1'b0;
    o.width     = kp_clear_n ? 0 : 1;
    o.bad_after = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) o.bad_after = bad_key;
      if (kp_clear_n) break;
      o.width++;
    end
    repeat (3) tick();
  endtask

  task automatic check_press(input string nm, input obs_t o, input logic exp_bad,
                             input logic [2:0] exp_cnt, input logic exp_ov);
    check({nm, ".pre_clr"},   o.pre_clr,   1);
    check({nm, ".clr"},       o.clr,       0);
    check({nm, ".bad"},       o.bad,       exp_bad);
    check({nm, ".bad_after"}, o.bad_after, 0);
    check({nm, ".cnt"},       o.cnt,       exp_cnt);
    check({nm, ".ov"},        o.ov,        exp_ov);
    check({nm, ".width"},     o.width,     8);
  endtask

  task automatic drain(input string nm, input logic [3:0] exp);
    check({nm, ".valid"}, ev_valid, 1);
    check({nm, ".key"},   ev_key,   exp);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
  endtask

  vec_t vecs[16];
  obs_t o;

  initial begin
    vecs[0]  = '{4'h6, 1'b0};
    vecs[1]  = '{4'hC, 1'b1};
    vecs[2]  = '{4'h0, 1'b0};
    vecs[3]  = '{4'h1, 1'b0};
    vecs[4]  = '{4'h2, 1'b0};
    vecs[5]  = '{4'h3, 1'b1};
    vecs[6]  = '{4'h4, 1'b0};
    vecs[7]  = '{4'h5, 1'b0};
    vecs[8]  = '{4'h7, 1'b1};
    vecs[9]  = '{4'h8, 1'b0};
    vecs[10] = '{4'h9, 1'b0};
    vecs[11] = '{4'hA, 1'b0};
    vecs[12] = '{4'hB, 1'b1};
    vecs[13] = '{4'hD, 1'b1};
    vecs[14] = '{4'hE, 1'b1};
    vecs[15] = '{4'hF, 1'b1};

    reset        = 1'b1;
    kp_valid_key = 1'b0;
    kp_key       = 4'h0;
    flush        = 1'b0;
    ev_ready     = 1'b0;

    // Reset held 3 cycles, then keypad clear stays low 8 cycles in total.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst.clr",  kp_clear_n, 0);
      check("rst.evv",  ev_valid,   0);
      check("rst.evk",  ev_key,     0);
      check("rst.cnt",  count,      0);
      check("rst.ov",   overflow,   0);
      check("rst.bad",  bad_key,    0);
    end
    reset = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      check("rst.hold_clr", kp_clear_n, 0);
      check("rst.hold_cnt", count, 0);
    end
    tick();
    check("rst.release_clr", kp_clear_n, 1);
    check("rst.release_evv", ev_valid, 0);
    repeat (3) tick();

    // Single press 0x6, head stays stable without ready, then popped.
    press(4'h6, 1'b0, 1'b0, o);
    check_press("single", o, 1'b0, 3'd1, 1'b0);
    check("single.evv", o.evv, 1);
    check("single.evk", o.evk, 4'h6);
    check("single.stable_key", ev_key, 4'h6);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check("single.pop_evv", ev_valid, 0);
    check("single.pop_cnt", count, 0);
    check("single.pop_evk", ev_key, 0);

    // Legality table: every code, drained after each legal push.
    for (int i = 0; i < 16; i++) begin
      string nm;
      nm = $sformatf("tbl%0h", vecs[i].key);
      press(vecs[i].key, 1'b0, 1'b0, o);
      check_press(nm, o, vecs[i].exp_bad, vecs[i].exp_bad ? 3'd0 : 3'd1, 1'b0);
      check({nm, ".evv"}, o.evv, !vecs[i].exp_bad);
      if (!vecs[i].exp_bad) begin
        check({nm, ".evk"}, o.evk, vecs[i].key);
        drain(nm, vecs[i].key);
      end
      check({nm, ".empty"}, count, 0);
    end

    // Overflow: five legal presses into a 4-deep queue.
    press(4'h0, 1'b0, 1'b0, o); check_press("ovf0", o, 1'b0, 3'd1, 1'b0);
    press(4'h1, 1'b0, 1'b0, o); check_press("ovf1", o, 1'b0, 3'd2, 1'b0);
    press(4'h2, 1'b0, 1'b0, o); check_press("ovf2", o, 1'b0, 3'd3, 1'b0);
    press(4'h4, 1'b0, 1'b0, o); check_press("ovf3", o, 1'b0, 3'd4, 1'b0);
    press(4'h5, 1'b0, 1'b0, o); check_press("ovf4", o, 1'b0, 3'd4, 1'b1);
    check("ovf4.head", o.evk, 4'h0);
    drain("ovf.d0", 4'h0);
    drain("ovf.d1", 4'h1);
    drain("ovf.d2", 4'h2);
    drain("ovf.d3", 4'h4);
    check("ovf.empty", ev_valid, 0);
    check("ovf.sticky", overflow, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("ovf.flush_clr", overflow, 0);

    // Full queue with a pop on the capture cycle accepts the new key.
    press(4'h0, 1'b0, 1'b0, o);
    press(4'h1, 1'b0, 1'b0, o);
    press(4'h2, 1'b0, 1'b0, o);
    press(4'h4, 1'b0, 1'b0, o);
    check("pp.fill", count, 4);
    press(4'hA, 1'b1, 1'b0, o);
    check_press("pp", o, 1'b0, 3'd4, 1'b0);
    check("pp.head", o.evk, 4'h1);
    drain("pp.d0", 4'h1);
    drain("pp.d1", 4'h2);
    drain("pp.d2", 4'h4);
    drain("pp.d3", 4'hA);
    check("pp.empty", count, 0);
    check("pp.ov", overflow, 0);

    // Flush on the capture cycle discards the capture but re-arm completes.
    press(4'h1, 1'b0, 1'b0, o);
    press(4'h2, 1'b0, 1'b0, o);
    check("fl.pre_cnt", count, 2);
    press(4'h9, 1'b0, 1'b1, o);
    check_press("fl", o, 1'b0, 3'd0, 1'b0);
    check("fl.evv", o.evv, 0);
    check("fl.after_cnt", count, 0);
    check("fl.after_evv", ev_valid, 0);

    // Reset in the middle of a re-arm with a queued entry.
    press(4'h5, 1'b0, 1'b0, o);
    kp_key       = 4'h8;
    kp_valid_key = 1'b1;
    repeat (5) tick();
    check("mid.in_rearm", kp_clear_n, 0);
    check("mid.cnt_pre", count, 2);
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    kp_valid_key = 1'b0;
    check("mid.clr", kp_clear_n, 0);
    check("mid.cnt", count, 0);
    check("mid.evv", ev_valid, 0);
    check("mid.evk", ev_key, 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("mid.hold_clr", kp_clear_n, 0);
    end
    tick();
    check("mid.release_clr", kp_clear_n, 1);
    check("mid.release_cnt", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
